// File: rtl/rvv_instr_queue.sv
// Instruction queue between the scalar core's vector-offload port and the
// vector decoder. Non-vector opcodes are accepted but dropped (flagged via a
// one-cycle illegal pulse); vector instructions are buffered in program order.
module rvv_instr_queue #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic          illegal,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [6:0] OPC_OP_V  = 7'b1010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000111;
    localparam logic [6:0] OPC_STORE = 7'b0100111;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          vec_push;
    logic          is_vec;

    // Only OP-V, vector load and vector store opcodes are queued.
    function automatic logic is_vector_opcode(input logic [6:0] opc);
        return (opc == OPC_OP_V) || (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

    // Status flags and handshakes decoded from registered state only.
    always_comb begin
        full      = (count == CW'(DEPTH));
        empty     = (count == '0);
        in_ready  = !full;
        out_valid = !empty;
        is_vec    = is_vector_opcode(in_instr[6:0]);
        push      = in_valid && in_ready;
        vec_push  = push && is_vec;
        pop       = out_valid && out_ready;
        out_instr = empty ? 32'h0000_0000 : mem[rd_ptr];
    end

    // Pointer, occupancy and illegal-pulse state; flush clears the queue but
    // still lets a dropped non-vector instruction report itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            illegal <= 1'b0;
        end else begin
            illegal <= push && !is_vec;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (vec_push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)      rd_ptr <= rd_ptr + 1'b1;
                if (vec_push && !pop)      count <= count + 1'b1;
                else if (!vec_push && pop) count <= count - 1'b1;
            end
        end
    end

    // Storage write; contents are never reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (vec_push && !flush && !rst) mem[wr_ptr] <= in_instr;
    end

endmodule

// File: tb/tb_rvv_instr_queue.sv
// Directed testbench for rvv_instr_queue (DEPTH = 4).
module tb_rvv_instr_queue;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready, illegal, full, empty;
    logic [31:0] in_instr, out_instr;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    rvv_instr_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .illegal(illegal),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; in_instr = 0; flush = 0; out_ready = 0;
        step(); step();
        rst = 0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    endtask

    task automatic test_fill();
        logic [31:0] v [4];
        v[0] = 32'h0020_8057; v[1] = 32'h0041_0157; v[2] = 32'h0000_7007; v[3] = 32'h0000_7027;
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_instr = v[i];
            step();
            checks++; if (count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
            checks++; if (out_instr !== 32'h0020_8057) begin failures++; $display("FAIL fill_head[%0d] got=%h exp=00208057", i, out_instr); end
        end
        in_valid = 0;
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    endtask

    task automatic test_full_drain();
        logic [31:0] exp_head [4];
        logic [2:0]  exp_cnt [4];
        exp_head[0] = 32'h0000_7007; exp_cnt[0] = 3'd2;
        exp_head[1] = 32'h0000_7027; exp_cnt[1] = 3'd1;
        exp_head[2] = 32'h0063_0257; exp_cnt[2] = 3'd0;
        exp_head[3] = 32'h0000_0000; exp_cnt[3] = 3'd0;
        out_ready = 1; in_valid = 1; in_instr = 32'h0063_0257;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready_with_out_ready got=%b exp=0", in_ready); end
        step();
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL full_pop_only_count got=%0d exp=3", count); end
        checks++; if (out_instr !== 32'h0041_0157) begin failures++; $display("FAIL full_pop_head got=%h exp=00410157", out_instr); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL resume_in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 0;
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL push_pop_count got=%0d exp=3", count); end
        checks++; if (out_instr !== 32'h0000_7007) begin failures++; $display("FAIL push_pop_head got=%h exp=00007007", out_instr); end
        // Remaining drain: entries C, D, then wrapped E, then empty.
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_instr !== exp_head[i + 1]) begin failures++; $display("FAIL drain_head[%0d] got=%h exp=%h", i, out_instr, exp_head[i + 1]); end
            checks++; if (count !== exp_cnt[i]) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, exp_cnt[i]); end
        end
        out_ready = 0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_illegal();
        in_valid = 1; in_instr = 32'h0000_7007;
        step();
        in_instr = 32'h0000_0013;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL nop_in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 0;
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL nop_illegal_pulse got=%b exp=1", illegal); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL nop_count got=%0d exp=1", count); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL nop_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_instr !== 32'h0000_7007) begin failures++; $display("FAIL nop_head got=%h exp=00007007", out_instr); end
        step();
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL nop_illegal_clear got=%b exp=0", illegal); end
    endtask

    task automatic test_flush();
        // One entry already queued; add two more to reach three.
        in_valid = 1; in_instr = 32'h0041_0157; step();
        in_instr = 32'h0000_7027; step();
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL preflush_count got=%0d exp=3", count); end
        flush = 1; out_ready = 1; in_instr = 32'h0020_8057;
        step();
        flush = 0; out_ready = 0; in_valid = 0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", empty); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL flush_out_instr got=%h exp=0", out_instr); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL flush_vec_illegal got=%b exp=0", illegal); end
        in_valid = 1; in_instr = 32'h0041_0157;
        step();
        in_valid = 0;
        checks++; if (out_instr !== 32'h0041_0157) begin failures++; $display("FAIL postflush_head got=%h exp=00410157", out_instr); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL postflush_count got=%0d exp=1", count); end
        // Flush with a non-vector instruction still pulses illegal.
        flush = 1; in_valid = 1; in_instr = 32'h0000_0013;
        step();
        flush = 0; in_valid = 0;
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL flush_nonvec_illegal got=%b exp=1", illegal); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush2_count got=%0d exp=0", count); end
        step();
    endtask

    task automatic test_single();
        in_valid = 1; in_instr = 32'h0C05_7057; out_ready = 1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%b exp=0", out_valid); end
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_instr !== 32'h0C05_7057) begin failures++; $display("FAIL single_head got=%h exp=0c057057", out_instr); end
        step();
        out_ready = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_out_valid_drop got=%b exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL single_out_instr_zero got=%h exp=0", out_instr); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1; in_instr = 32'h0020_8057; step();
        in_instr = 32'h0041_0157; step();
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL prerst_count got=%0d exp=2", count); end
        rst = 1; in_instr = 32'h0000_0013; out_ready = 1;
        step();
        rst = 0; in_valid = 0; out_ready = 0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL rst_mid_illegal got=%b exp=0", illegal); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
        step();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_mid_empty_hold got=%b exp=1", empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_drain();
        test_illegal();
        test_flush();
        test_single();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rvv_instr_queue.md
# rvv_instr_queue

Instruction queue between the scalar core's vector-offload port and `rvv_vector_decoder`. It accepts 32-bit instructions over a valid/ready handshake and drops non-vector opcodes, pulsing `illegal` for each. Vector instructions are buffered in a DEPTH-entry FIFO and presented to the decoder's `instr` input in program order. A synchronous `flush` discards all buffered instructions on a core redirect or exception.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, ≥ 2
- CW, $clog2(DEPTH+1), width of `count` (derived, not overridden)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  queue can accept this cycle
- in_instr  in  32  instruction from scalar core
- flush  in  1  discard all queued entries
- out_valid  out  1  head entry valid; drives decoder
- out_ready  in  1  downstream consumed head this cycle
- out_instr  out  32  head instruction, to `rvv_vector_decoder.instr`
- illegal  out  1  one-cycle pulse: an accepted instruction was non-vector and dropped
- count  out  CW  number of valid entries, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Push handshake: `push = in_valid && in_ready`. Pop handshake: `pop = out_valid && out_ready`.
- `in_ready = !full`. Does not depend on `out_ready`, so there is no combinational path from output to input.
- Vector opcodes, `in_instr[6:0]`:
  - 7'b1010111 OP-V: arithmetic, vsetvli, vsetvl
  - 7'b0000111 vector load
  - 7'b0100111 vector store
- An accepted instruction with any other opcode is not written. `illegal` is asserted on the following cycle for exactly one cycle.
- An accepted vector instruction is written to `mem[wr_ptr]`, and `wr_ptr` increments.
- On pop, `rd_ptr` increments.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `count` update:
  - +1 on a vector push only
  - −1 on pop only
  - unchanged on vector push with pop
  - unchanged on a non-vector push
- `out_valid = !empty`.
- `out_instr = mem[rd_ptr]` when non-empty. It is forced to 32'h0000_0000 when empty, so the decoder sees opcode 0: not vector, not load, not store.
- Flush:
  - Next state is `count = 0` and `wr_ptr = rd_ptr = 0`.
  - It overrides any same-cycle push or pop; the pushed instruction is discarded.
  - The upstream handshake still completes: `in_ready` keeps its pre-flush value.
  - `illegal` is still pulsed for a non-vector instruction accepted in the flush cycle.
- Reset state:
  - count 0, empty 1, full 0
  - in_ready 1, out_valid 0
  - out_instr 0, illegal 0
  - pointers 0; memory contents are not reset

## Timing
- Push-to-output latency: 1 cycle. An instruction accepted at edge N is visible on `out_instr`/`out_valid` after edge N, with no same-cycle bypass.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- When full, `in_ready` = 0 for the whole cycle even if `out_ready` = 1. Push resumes the cycle after a pop.
- When empty and `in_valid` = 1: the entry is written, and `out_valid` rises the next cycle.
- `out_instr` must be held stable while `out_valid && !out_ready`. The decoder samples vsetvl* into `vtype_reg` on the pop edge, and the next entry appears the cycle after.
- `rst` overrides `flush`, push and pop. `rst` asserted mid-stream empties the queue on the next edge with no `illegal` pulse.
- `illegal` and `count` are registered outputs. `in_ready`, `out_valid`, `full`, `empty` and `out_instr` are decoded from registered state only.

## Test plan
- Reset, then push four instructions 0x0020_8057, 0x0041_0157, 0x0000_7007, 0x0000_7027 with `out_ready` = 0. Expect:
  - count 1,2,3,4
  - `full` = 1 and `in_ready` = 0 after the 4th push
  - `out_instr` = 0x0020_8057 held throughout
- From full, assert `out_ready` = 1 and `in_valid` = 1 with 0x0063_0257. Expect:
  - no push on the full cycle
  - the next cycle pushes and pops together, and count stays 3
  - pops come out in FIFO order, and `rd_ptr` wraps correctly across the DEPTH boundary
- Push 0x0000_0013 (addi nop). Expect:
  - accepted (`in_ready` = 1)
  - `illegal` = 1 for exactly one cycle, then 0
  - count unchanged, `out_valid` unchanged
- With 3 entries queued, assert `flush` together with a push of 0x0020_8057 and a pop. Expect:
  - next cycle count 0, empty 1, `out_valid` 0, `out_instr` 0
  - a subsequent push appears at the head one cycle later
- Empty queue with a single push of vsetvli 0x0C05_7057, `out_ready` = 1. Expect:
  - `out_valid` high for exactly one cycle, the cycle after the push
  - then empty, with `out_instr` returning to 0
- Assert `rst` while 2 entries are queued and `in_valid` = 1. Expect count 0, `in_ready` 1 and `illegal` 0 on the next cycle, with no entry retained.
